// File: rtl/rdy_vld_arb_fifo.sv
// N-channel round-robin rdy/vld funnel into a DEPTH-entry FIFO, head tagged with source channel.
// Optional same-cycle bypass when empty: define RDY_VLD_ARB_FIFO_BYPASS_EN.
module rdy_vld_arb_fifo #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 7,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          in_vld,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  output logic [NUM_CH-1:0]          in_rdy,
  input  logic [NUM_CH-1:0]          hold_mask,
  output logic                       out_vld,
  output logic [DATA_W-1:0]          out_data,
  output logic [CH_W-1:0]            out_ch,
  input  logic                       out_rdy,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = CH_W + DATA_W;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic [EW-1:0]     mem_q [DEPTH];

  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic [CH_W-1:0]   arb_idx;
  logic              gnt_vld;
  logic [CH_W-1:0]   gnt;
  logic              can_accept;
  logic              push;
  logic              pop;
  logic              mem_wr;
  logic              fifo_empty;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_data[i] = in_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    elig    = in_vld & ~hold_mask;
    gnt_vld = 1'b0;
    gnt     = '0;
    arb_idx = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      arb_idx = CH_W'((32'(rr_ptr_q) + k) % NUM_CH);
      if (!gnt_vld && elig[arb_idx]) begin
        gnt_vld = 1'b1;
        gnt     = arb_idx;
      end
    end
  end

  // Full blocks pushes even when a pop happens in the same cycle.
  assign can_accept = rst_n && (count_q != FullCnt);
  assign push       = gnt_vld && can_accept;
  assign fifo_empty = (count_q == '0);

  always_comb begin
    in_rdy = '0;
    if (push) begin
      in_rdy[gnt] = 1'b1;
    end
  end

`ifdef RDY_VLD_ARB_FIFO_BYPASS_EN
  logic bypass;

  // Empty FIFO with a ready consumer forwards the granted word without storing it.
  assign bypass   = fifo_empty && push && out_rdy;
  assign out_vld  = rst_n && (!fifo_empty || bypass);
  assign out_data = bypass ? ch_data[gnt] : mem_q[rd_ptr_q][DATA_W-1:0];
  assign out_ch   = bypass ? gnt : mem_q[rd_ptr_q][EW-1:DATA_W];
  assign pop      = rst_n && !fifo_empty && out_rdy;
  assign mem_wr   = push && !bypass;
`else
  assign out_vld  = rst_n && !fifo_empty;
  assign out_data = mem_q[rd_ptr_q][DATA_W-1:0];
  assign out_ch   = mem_q[rd_ptr_q][EW-1:DATA_W];
  assign pop      = out_vld && out_rdy;
  assign mem_wr   = push;
`endif

  always_comb begin
    count_d = count_q;
    case ({mem_wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  assign occupancy = rst_n ? count_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_ptr_q <= CH_W'(NUM_CH - 1);
    end else begin
      count_q <= count_d;
      if (mem_wr) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push) begin
        rr_ptr_q <= gnt;
      end
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem_q[wr_ptr_q] <= {gnt, ch_data[gnt]};
    end
  end

endmodule
